hazard3_sbus_to_ahb: RTL and testbench

HAZARD3_SBUS_TO_AHB -- requirements
Module: hazard3_sbus_to_ahb

---
 rtl/hazard3_sbus_to_ahb.sv | 160 ++++++++++++++++
 tb/tb_hazard3_sbus_to_ahb.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard3_sbus_to_ahb.sv
// Bridge from the Hazard3 debug-module system-bus port to a single-transfer AHB-Lite master.
// Optional alignment checking of halfword/word requests: define HAZARD3_SBUS_ALIGN_CHECK_EN.
module hazard3_sbus_to_ahb #(
    parameter int W_ADDR = 32,
    parameter int W_DATA = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [31:0]       sbus_addr,
    input  logic              sbus_write,
    input  logic [1:0]        sbus_size,
    input  logic              sbus_vld,
    output logic              sbus_rdy,
    output logic              sbus_err,
    input  logic [31:0]       sbus_wdata,
    output logic [31:0]       sbus_rdata,

    output logic [W_ADDR-1:0] ahb_haddr,
    output logic              ahb_hwrite,
    output logic [1:0]        ahb_htrans,
    output logic [2:0]        ahb_hsize,
    output logic [2:0]        ahb_hburst,
    output logic [3:0]        ahb_hprot,
    output logic              ahb_hmastlock,
    input  logic              ahb_hready,
    input  logic              ahb_hresp,
    output logic [W_DATA-1:0] ahb_hwdata,
    input  logic [W_DATA-1:0] ahb_hrdata,

    output logic [1:0]        dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_RESP = 2'd3
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    // Handshake: sbus_vld is held with stable request fields until the one-cycle
    // sbus_rdy pulse; sbus_err and sbus_rdata are only meaningful while sbus_rdy=1.
    state_t              state_q;
    logic [W_ADDR-1:0]   haddr_q;
    logic                hwrite_q;
    logic [2:0]          hsize_q;
    logic [1:0]          htrans_q;
    logic [W_DATA-1:0]   hwdata_q;
    logic                rdy_q;
    logic                err_q;
    logic [31:0]         rdata_q;

    logic                req_bad;
    logic [W_DATA-1:0]   wdata_rep;
    logic [W_DATA-1:0]   rd_shift;
    logic [31:0]         rd_ext;

    always_comb begin
        req_bad = (sbus_size == 2'b11);
`ifdef HAZARD3_SBUS_ALIGN_CHECK_EN
        if (sbus_size == 2'b01 && sbus_addr[0])
            req_bad = 1'b1;
        if (sbus_size == 2'b10 && sbus_addr[1:0] != 2'b00)
            req_bad = 1'b1;
`endif
    end

    // Narrow writes are replicated across all byte lanes so the slave can pick its lane by address.
    always_comb begin
        case (sbus_size)
            2'b00:   wdata_rep = {4{sbus_wdata[7:0]}};
            2'b01:   wdata_rep = {2{sbus_wdata[15:0]}};
            default: wdata_rep = sbus_wdata;
        endcase
    end

    always_comb begin
        rd_shift = ahb_hrdata >> {haddr_q[1:0], 3'b000};
        case (hsize_q[1:0])
            2'b00:   rd_ext = {24'h0, rd_shift[7:0]};
            2'b01:   rd_ext = {16'h0, rd_shift[15:0]};
            default: rd_ext = rd_shift;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            haddr_q  <= '0;
            hwrite_q <= 1'b0;
            hsize_q  <= 3'b000;
            htrans_q <= HTRANS_IDLE;
            hwdata_q <= '0;
            rdy_q    <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= 32'h0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (sbus_vld) begin
                        if (req_bad) begin
                            state_q <= S_RESP;
                            rdy_q   <= 1'b1;
                            err_q   <= 1'b1;
                            rdata_q <= 32'h0;
                        end else begin
                            state_q  <= S_ADDR;
                            htrans_q <= HTRANS_NONSEQ;
                            haddr_q  <= W_ADDR'(sbus_addr);
                            hwrite_q <= sbus_write;
                            hsize_q  <= {1'b0, sbus_size};
                            hwdata_q <= wdata_rep;
                        end
                    end
                end
                S_ADDR: begin
                    if (ahb_hready) begin
                        state_q  <= S_DATA;
                        htrans_q <= HTRANS_IDLE;
                    end
                end
                // The first cycle of a two-cycle error response has hready=0 and is simply waited out.
                S_DATA: begin
                    if (ahb_hready) begin
                        state_q <= S_RESP;
                        rdy_q   <= 1'b1;
                        err_q   <= ahb_hresp;
                        rdata_q <= (ahb_hresp || hwrite_q) ? 32'h0 : rd_ext;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                    rdy_q   <= 1'b0;
                    err_q   <= 1'b0;
                    rdata_q <= 32'h0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign sbus_rdy      = rdy_q;
    assign sbus_err      = err_q;
    assign sbus_rdata    = rdata_q;

    assign ahb_haddr     = haddr_q;
    assign ahb_hwrite    = hwrite_q;
    assign ahb_htrans    = htrans_q;
    assign ahb_hsize     = hsize_q;
    assign ahb_hwdata    = hwdata_q;
    assign ahb_hburst    = 3'b000;
    assign ahb_hprot     = 4'b0011;
    assign ahb_hmastlock = 1'b0;

    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_hazard3_sbus_to_ahb.sv
// Directed bench for hazard3_sbus_to_ahb: AHB slave model, request driver and response scoreboard.
`timescale 1ns/1ps
module tb_hazard3_sbus_to_ahb;

    localparam int EW = 8 + 1 + 32;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] sbus_addr;
    logic        sbus_write;
    logic [1:0]  sbus_size;
    logic        sbus_vld;
    logic        sbus_rdy;
    logic        sbus_err;
    logic [31:0] sbus_wdata;
    logic [31:0] sbus_rdata;
    logic [31:0] ahb_haddr;
    logic        ahb_hwrite;
    logic [1:0]  ahb_htrans;
    logic [2:0]  ahb_hsize;
    logic [2:0]  ahb_hburst;
    logic [3:0]  ahb_hprot;
    logic        ahb_hmastlock;
    logic        ahb_hready;
    logic        ahb_hresp;
    logic [31:0] ahb_hwdata;
    logic [31:0] ahb_hrdata;
    logic [1:0]  dbg_state;

    hazard3_sbus_to_ahb #(.W_ADDR(32), .W_DATA(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .sbus_addr     (sbus_addr),
        .sbus_write    (sbus_write),
        .sbus_size     (sbus_size),
        .sbus_vld      (sbus_vld),
        .sbus_rdy      (sbus_rdy),
        .sbus_err      (sbus_err),
        .sbus_wdata    (sbus_wdata),
        .sbus_rdata    (sbus_rdata),
        .ahb_haddr     (ahb_haddr),
        .ahb_hwrite    (ahb_hwrite),
        .ahb_htrans    (ahb_htrans),
        .ahb_hsize     (ahb_hsize),
        .ahb_hburst    (ahb_hburst),
        .ahb_hprot     (ahb_hprot),
        .ahb_hmastlock (ahb_hmastlock),
        .ahb_hready    (ahb_hready),
        .ahb_hresp     (ahb_hresp),
        .ahb_hwdata    (ahb_hwdata),
        .ahb_hrdata    (ahb_hrdata),
        .dbg_state_o   (dbg_state)
    );

    // Clock / cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard state
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_e;
    int n_vec  = 0;
    int n_miss = 0;
    int t_start = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every sbus_rdy pulse must match the oldest expected response.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && sbus_rdy) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL unexpected_rdy: got sbus_rdy=1 at cycle %0d, expected none", cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("latency", 32'(cyc - t_start), {24'h0, mon_e[40:33]});
                    chk("sbus_err", {31'h0, sbus_err}, {31'h0, mon_e[32]});
                    chk("sbus_rdata", sbus_rdata, mon_e[31:0]);
                end
            end
        end
    end

    // AHB slave model
    int          slv_wait = 0;
    bit          slv_err = 1'b0;
    logic [31:0] slv_rdata = 32'h0;
    int          nonseq_cnt = 0;
    bit          addr_taken = 1'b0;
    bit          in_data = 1'b0;
    int          dcnt = 0;
    logic [31:0] cap_haddr = 32'h0;
    logic        cap_hwrite = 1'b0;
    logic [2:0]  cap_hsize = 3'h0;
    logic [31:0] cap_hwdata = 32'h0;

    initial begin
        ahb_hready = 1'b1;
        ahb_hresp  = 1'b0;
        ahb_hrdata = 32'h0;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_data    = 1'b0;
                addr_taken = 1'b0;
                ahb_hready = 1'b1;
                ahb_hresp  = 1'b0;
            end else begin
                if (addr_taken) begin
                    in_data    = 1'b1;
                    dcnt       = 0;
                    addr_taken = 1'b0;
                end
                if (in_data) begin
                    if (dcnt < slv_wait) begin
                        ahb_hready = 1'b0;
                        ahb_hresp  = 1'b0;
                    end else if (slv_err && dcnt == slv_wait) begin
                        ahb_hready = 1'b0;
                        ahb_hresp  = 1'b1;
                    end else begin
                        ahb_hready = 1'b1;
                        ahb_hresp  = slv_err;
                        ahb_hrdata = slv_rdata;
                        cap_hwdata = ahb_hwdata;
                        in_data    = 1'b0;
                    end
                    dcnt++;
                    if (!ahb_hready)
                        chk("htrans_during_wait", {30'h0, ahb_htrans}, 32'h0);
                end else begin
                    ahb_hready = 1'b1;
                    ahb_hresp  = 1'b0;
                    ahb_hrdata = 32'hDEADBEEF;
                end
                if (ahb_htrans == 2'b10 && ahb_hready) begin
                    addr_taken = 1'b1;
                    nonseq_cnt++;
                    cap_haddr  = ahb_haddr;
                    cap_hwrite = ahb_hwrite;
                    cap_hsize  = ahb_hsize;
                end
            end
        end
    end

    // Driver: issues one request and checks what the slave saw on the bus.
    task automatic do_req(input string name, input logic [31:0] addr, input logic wr,
                          input logic [1:0] sz, input logic [31:0] wd,
                          input int waits, input bit serr, input logic [31:0] srd,
                          input bit exp_issue, input logic exp_err, input logic [31:0] exp_rd,
                          input int exp_lat, input logic [31:0] exp_hwdata);
        int n0;
        bit done;
        slv_wait  = waits;
        slv_err   = serr;
        slv_rdata = srd;
        n0 = nonseq_cnt;
        exp_q.push_back({8'(exp_lat), exp_err, exp_rd});
        t_start    = cyc;
        sbus_addr  = addr;
        sbus_write = wr;
        sbus_size  = sz;
        sbus_wdata = wd;
        sbus_vld   = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (sbus_rdy) done = 1'b1;
        end
        sbus_vld = 1'b0;
        if (!done) begin
            n_vec++;
            n_miss++;
            $display("FAIL %s_timeout: got no sbus_rdy, expected one within 50 cycles", name);
            exp_q.delete();
        end
        repeat (3) @(negedge clk);
        chk({name, "_nonseq_count"}, 32'(nonseq_cnt - n0), {31'h0, exp_issue});
        if (exp_issue) begin
            chk({name, "_haddr"}, cap_haddr, addr);
            chk({name, "_hwrite"}, {31'h0, cap_hwrite}, {31'h0, wr});
            chk({name, "_hsize"}, {29'h0, cap_hsize}, {30'h0, sz});
            if (wr)
                chk({name, "_hwdata"}, cap_hwdata, exp_hwdata);
        end
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_htrans"}, {30'h0, ahb_htrans}, 32'h0);
        chk({name, "_rdy"}, {31'h0, sbus_rdy}, 32'h0);
        chk({name, "_err"}, {31'h0, sbus_err}, 32'h0);
        chk({name, "_rdata"}, sbus_rdata, 32'h0);
        chk({name, "_haddr"}, ahb_haddr, 32'h0);
        chk({name, "_hwrite"}, {31'h0, ahb_hwrite}, 32'h0);
        chk({name, "_hsize"}, {29'h0, ahb_hsize}, 32'h0);
        chk({name, "_hwdata"}, ahb_hwdata, 32'h0);
        chk({name, "_state"}, {30'h0, dbg_state}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no end of test, expected finish before 200us");
        $fatal(1, "timeout");
    end

    initial begin
        rst        = 1'b1;
        sbus_addr  = 32'h0;
        sbus_write = 1'b0;
        sbus_size  = 2'b00;
        sbus_wdata = 32'h0;
        sbus_vld   = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        //     name        addr          wr    sz     wdata         wt err srdata        iss err rdata        lat hwdata
        do_req("word_wr",  32'h20000010, 1'b1, 2'd2, 32'hCAFEF00D, 0, 0, 32'h00000000, 1, 0, 32'h00000000, 3, 32'hCAFEF00D);
        do_req("byte_rd3", 32'h20000003, 1'b0, 2'd0, 32'h00000000, 0, 0, 32'hA5000000, 1, 0, 32'h000000A5, 3, 32'h0);
        do_req("half_wait",32'h20000002, 1'b0, 2'd1, 32'h00000000, 2, 0, 32'hBEEF1234, 1, 0, 32'h0000BEEF, 5, 32'h0);
        do_req("half_rd0", 32'h20000000, 1'b0, 2'd1, 32'h00000000, 0, 0, 32'hBEEF1234, 1, 0, 32'h00001234, 3, 32'h0);
        do_req("err_wr",   32'h20000020, 1'b1, 2'd2, 32'h11223344, 0, 1, 32'hFFFFFFFF, 1, 1, 32'h00000000, 4, 32'h11223344);
        do_req("err_rd",   32'h20000008, 1'b0, 2'd2, 32'h00000000, 1, 1, 32'h12345678, 1, 1, 32'h00000000, 5, 32'h0);
        do_req("size3_rd", 32'h20000040, 1'b0, 2'd3, 32'h00000000, 0, 0, 32'h12345678, 0, 1, 32'h00000000, 1, 32'h0);
        do_req("size3_wr", 32'h20000044, 1'b1, 2'd3, 32'h87654321, 0, 0, 32'h00000000, 0, 1, 32'h00000000, 1, 32'h0);
        do_req("byte_wr",  32'h20000001, 1'b1, 2'd0, 32'hFFFFFFAB, 0, 0, 32'h00000000, 1, 0, 32'h00000000, 3, 32'hABABABAB);
        do_req("half_wr",  32'h20000002, 1'b1, 2'd1, 32'h9999C3D4, 0, 0, 32'h00000000, 1, 0, 32'h00000000, 3, 32'hC3D4C3D4);
        do_req("byte_rd1", 32'h20000001, 1'b0, 2'd0, 32'h00000000, 0, 0, 32'h00CC5A00, 1, 0, 32'h0000005A, 3, 32'h0);
`ifdef HAZARD3_SBUS_ALIGN_CHECK_EN
        do_req("mis_word", 32'h20000012, 1'b0, 2'd2, 32'h00000000, 0, 0, 32'h12345678, 0, 1, 32'h00000000, 1, 32'h0);
        do_req("mis_half", 32'h20000005, 1'b1, 2'd1, 32'h0000BEEF, 0, 0, 32'h00000000, 0, 1, 32'h00000000, 1, 32'h0);
`else
        do_req("mis_word", 32'h20000012, 1'b0, 2'd2, 32'h00000000, 0, 0, 32'h12345678, 1, 0, 32'h00001234, 3, 32'h0);
        do_req("mis_half", 32'h20000005, 1'b1, 2'd1, 32'h0000BEEF, 0, 0, 32'h00000000, 1, 0, 32'h00000000, 3, 32'hBEEFBEEF);
`endif

        // Reset pulsed while the bridge sits in a stalled data phase.
        slv_wait   = 6;
        slv_err    = 1'b0;
        sbus_addr  = 32'h20000030;
        sbus_write = 1'b1;
        sbus_size  = 2'd2;
        sbus_wdata = 32'h55AA55AA;
        sbus_vld   = 1'b1;
        repeat (2) @(negedge clk);
        chk("mid_state_data", {30'h0, dbg_state}, 32'd2);
        rst      = 1'b1;
        sbus_vld = 1'b0;
        #1;
        chk_reset_outputs("mid_reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        do_req("post_rst", 32'h20000004, 1'b0, 2'd2, 32'h00000000, 0, 0, 32'h0BADF00D, 1, 0, 32'h0BADF00D, 3, 32'h0);

        chk("hburst", {29'h0, ahb_hburst}, 32'h0);
        chk("hmastlock", {31'h0, ahb_hmastlock}, 32'h0);
        chk("hprot", {28'h0, ahb_hprot}, 32'h3);
        chk("queue_drained", exp_q.size(), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
